// File: rtl/rriot_timer.sv
// RRIOT-style 8-bit interval timer with 1/8/64/1024 prescaler, post-zero free run and IRQ flag.
// Optional RRIOT_TIMER_IRQ_REG_EN: registers irq one cycle behind flag & irq_en.
module rriot_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs,
   input  logic       we_n,
   input  logic [2:0] A,
   input  logic [7:0] DI,
   output logic [7:0] DO,
   output logic       OE,
   output logic       irq
);

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_POSTZERO} t_state;

   t_state      r_state, w_state_next;
   logic [7:0]  r_cnt;
   logic [1:0]  r_div_sel;
   logic [9:0]  r_pre;
   logic        r_flag;
   logic        r_irq_en;
   logic [7:0]  r_do;
   logic        r_oe;

   logic        w_write, w_read, w_rd_timer, w_tick;
   logic        w_cnt_dec, w_flag_set;

   function automatic logic [9:0] f_div_m1(input logic [1:0] sel);
      case (sel)
         2'd0:    f_div_m1 = 10'd0;
         2'd1:    f_div_m1 = 10'd7;
         2'd2:    f_div_m1 = 10'd63;
         default: f_div_m1 = 10'd1023;
      endcase
   endfunction

   assign w_write    = cs & ~we_n;
   assign w_read     = cs & we_n;
   assign w_rd_timer = w_read & ~A[0];
   assign w_tick     = (r_pre == 10'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (w_write) begin
         w_state_next = S_COUNT;
      end else begin
         case (r_state)
            S_COUNT:  if (w_tick && r_cnt == 8'h00) w_state_next = S_POSTZERO;
            default:  w_state_next = r_state;
         endcase
      end
   end

   // Decrement in POSTZERO wraps 00 -> FF naturally, which also covers the FF load on expiry.
   always_comb begin
      w_cnt_dec  = 1'b0;
      w_flag_set = 1'b0;
      case (r_state)
         S_COUNT: begin
            w_cnt_dec  = w_tick;
            w_flag_set = w_tick && (r_cnt == 8'h00);
         end
         S_POSTZERO: w_cnt_dec = 1'b1;
         default: begin
            w_cnt_dec  = 1'b0;
            w_flag_set = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= 8'h00;
         r_div_sel <= 2'd0;
         r_pre     <= 10'd0;
         r_flag    <= 1'b0;
         r_irq_en  <= 1'b0;
         r_do      <= 8'h00;
         r_oe      <= 1'b0;
      end else begin
         r_oe <= w_read;
         if (w_read) r_do <= A[0] ? {r_flag, 7'b0} : r_cnt;
         if (w_write) begin
            r_cnt     <= DI;
            r_div_sel <= A[1:0];
            r_irq_en  <= A[2];
            r_pre     <= f_div_m1(A[1:0]);
            r_flag    <= 1'b0;
         end else begin
            r_pre <= w_tick ? f_div_m1(r_div_sel) : r_pre - 10'd1;
            if (w_cnt_dec) r_cnt <= r_cnt - 8'd1;
            // An expiry in the same cycle as a timer read wins over the clear.
            if (w_flag_set)      r_flag <= 1'b1;
            else if (w_rd_timer) r_flag <= 1'b0;
            if (w_rd_timer) r_irq_en <= A[2];
         end
      end
   end

   assign DO = r_do;
   assign OE = r_oe;

`ifdef RRIOT_TIMER_IRQ_REG_EN
   logic r_irq;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_irq <= 1'b0;
      else     r_irq <= r_flag & r_irq_en;
   end
   assign irq = r_irq;
`else
   assign irq = r_flag & r_irq_en;
`endif

endmodule

// File: tb/tb_rriot_timer.sv
// Directed self-checking bench for rriot_timer (default build, combinational irq).
module tb_rriot_timer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cs = 1'b0;
   logic       we_n = 1'b1;
   logic [2:0] A = 3'b000;
   logic [7:0] DI = 8'h00;
   logic [7:0] DO;
   logic       OE;
   logic       irq;

   int checks = 0;
   int errors = 0;

   rriot_timer dut (
      .clk(clk), .rst(rst), .cs(cs), .we_n(we_n), .A(A),
      .DI(DI), .DO(DO), .OE(OE), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_write(input logic [2:0] a, input logic [7:0] d);
      cs = 1'b1; we_n = 1'b0; A = a; DI = d;
      @(posedge clk);
      #1;
      cs = 1'b0; we_n = 1'b1;
      $display("write A=%b DI=%h", a, d);
   endtask

   task automatic do_read(input logic [2:0] a);
      cs = 1'b1; we_n = 1'b1; A = a;
      @(posedge clk);
      #1;
      cs = 1'b0;
      $display("read  A=%b DO=%h OE=%b irq=%b", a, DO, OE, irq);
   endtask

   initial begin
      // Reset state
      idle(2);
      chk("rst_do", DO, 8'h00);
      chk("rst_oe", {7'b0, OE}, 8'h00);
      chk("rst_irq", {7'b0, irq}, 8'h00);
      rst = 1'b0;

      // Long idle, then reads
      idle(2000);
      do_read(3'b000);
      chk("idle_cnt", DO, 8'h00);
      chk("idle_oe", {7'b0, OE}, 8'h01);
      chk("idle_irq", {7'b0, irq}, 8'h00);
      idle(1);
      chk("oe_drop", {7'b0, OE}, 8'h00);
      chk("do_hold", DO, 8'h00);
      do_read(3'b001);
      chk("idle_flag", DO, 8'h00);

      // Divide by 1, N=3, irq enabled: flag at k+4
      do_write(3'b100, 8'h03);
      chk("wr_oe", {7'b0, OE}, 8'h00);
      idle(3);
      chk("d1_irq_k3", {7'b0, irq}, 8'h00);
      idle(1);
      chk("d1_irq_k4", {7'b0, irq}, 8'h01);
      idle(1);
      do_read(3'b100);
      chk("d1_cnt_fe", DO, 8'hFE);
      chk("d1_irq_clr", {7'b0, irq}, 8'h00);
      do_read(3'b100);
      chk("d1_cnt_fd", DO, 8'hFD);
      chk("d1_oe", {7'b0, OE}, 8'h01);

      // Divide by 1024, N=2, irq off: flag at k+3072
      do_write(3'b011, 8'h02);
      idle(3071);
      do_read(3'b001);
      chk("d1024_flag_pre", DO, 8'h00);
      do_read(3'b001);
      chk("d1024_flag_set", DO, 8'h80);
      chk("d1024_irq_off", {7'b0, irq}, 8'h00);

      // Timer read clears flag and enables irq; POSTZERO keeps running
      do_read(3'b100);
      chk("pz_cnt_fe", DO, 8'hFE);
      chk("pz_irq", {7'b0, irq}, 8'h00);
      do_read(3'b100);
      chk("pz_cnt_fd", DO, 8'hFD);
      do_read(3'b001);
      chk("pz_flag_clr", DO, 8'h00);

      // Write coinciding with the divide-by-8 expiry tick
      do_write(3'b001, 8'h00);
      idle(7);
      do_write(3'b011, 8'h55);
      do_read(3'b001);
      chk("wr_over_flag", DO, 8'h00);
      do_read(3'b000);
      chk("wr_over_cnt", DO, 8'h55);

      // Timer read coinciding with flag set
      do_write(3'b100, 8'h01);
      idle(1);
      do_read(3'b100);
      chk("rd_set_cnt", DO, 8'h00);
      chk("rd_set_irq", {7'b0, irq}, 8'h01);
      do_read(3'b001);
      chk("rd_set_flag", DO, 8'h80);
      chk("pz_irq_on", {7'b0, irq}, 8'h01);

      // Asynchronous reset mid-POSTZERO
      #2;
      rst = 1'b1;
      #1;
      chk("arst_irq", {7'b0, irq}, 8'h00);
      chk("arst_oe", {7'b0, OE}, 8'h00);
      chk("arst_do", DO, 8'h00);
      idle(1);
      rst = 1'b0;
      idle(20);
      do_read(3'b000);
      chk("post_rst_cnt", DO, 8'h00);
      idle(10);
      do_read(3'b000);
      chk("post_rst_idle", DO, 8'h00);
      do_read(3'b001);
      chk("post_rst_flag", DO, 8'h00);
      do_write(3'b000, 8'h02);
      do_read(3'b000);
      chk("resume_cnt", DO, 8'h02);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
